// File: rtl/stdout_uart_pkg.sv
// ---------------------------------------------------------------------------
// stdout_uart_pkg
// Shared definitions for the stdout UART: the transmitter state encoding and
// the 8N1 frame constants. Imported by stdout_uart.
// ---------------------------------------------------------------------------
package stdout_uart_pkg;

   // Transmitter states: idle line, start bit, eight data bits, stop bit
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // 8N1 framing
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;
   localparam int   DATA_BITS  = 8;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a power-of-two depth and a show-ahead read port
// (pop_data is always the head entry).
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset (empties the FIFO)
//   push        - write push_data this cycle (ignored when full, unless a
//                 pop on the same edge frees the slot)
//   push_data   - byte to write
//   pop         - remove the head entry this cycle (ignored when empty)
//   pop_data    - current head entry
//   full, empty - occupancy flags
//   count       - current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE        = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   // A pop on the same edge frees a slot, so a push into a full FIFO is still
   // accepted when it coincides with a pop.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign full     = (count_q == FULL_COUNT);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem[rd_ptr];

   // Storage array; no reset needed since occupancy is tracked separately
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count_q <= count_q + ONE;
         else if (do_pop && !do_push)
            count_q <= count_q - ONE;
      end
   end

endmodule

// File: rtl/stdout_uart.sv
// ---------------------------------------------------------------------------
// stdout_uart
// Turns the processor's byte-output strobe into an 8N1 serial stream. Each
// rising edge of stdout_en queues one byte in a FIFO; the transmitter drains
// the FIFO one frame at a time.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   stdout      - byte from the processor
//   stdout_en   - byte-valid strobe (may stay high while the CPU is halted)
//   txd         - serial line, idle high, registered
//   cpu_hold    - registered; asks the processor to stop outputting when the
//                 FIFO is nearly full
//   busy        - FIFO non-empty or a frame in flight
//   overflow    - sticky: a byte was dropped on a full FIFO
//   fifo_count  - current FIFO occupancy
// ---------------------------------------------------------------------------
module stdout_uart
   import stdout_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    stdout,
   input  logic                          stdout_en,
   output logic                          txd,
   output logic                          cpu_hold,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int CW     = $clog2(FIFO_DEPTH) + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]     HOLD_LEVEL = CW'(FIFO_DEPTH - 2);
   localparam logic [CW-1:0]     CNT_ONE    = CW'(1);
   localparam logic [2:0]        LAST_BIT   = 3'(DATA_BITS - 1);

   tx_state_t         state;
   tx_state_t         state_next;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        data_reg;
   logic              bit_done;
   logic              txd_next;
   logic              txd_q;

   logic              en_q;
   logic              armed;
   logic              accept;
   logic              do_push;
   logic              do_pop;
   logic              drop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [7:0]        fifo_head;
   logic [CW-1:0]     count_next;
   logic              cpu_hold_q;
   logic              overflow_q;

   // Edge detect on stdout_en. 'armed' only sets once stdout_en has been seen
   // low after reset, so a strobe already high at reset release is ignored
   // until it drops and rises again.
   always_ff @(posedge clk) begin
      if (reset) begin
         en_q  <= 1'b0;
         armed <= 1'b0;
      end else begin
         en_q  <= stdout_en;
         armed <= armed | ~stdout_en;
      end
   end

   assign accept  = stdout_en && !en_q && armed;
   assign do_pop  = (state == IDLE) && !fifo_empty;
   assign do_push = accept && (!fifo_full || do_pop);
   assign drop    = accept && fifo_full && !do_pop;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (do_push),
      .push_data (stdout),
      .pop       (do_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Occupancy after this edge, so the registered cpu_hold lines up with
   // fifo_count rather than trailing it by a cycle
   always_comb begin
      count_next = fifo_count;
      if (do_push && !do_pop)
         count_next = fifo_count + CNT_ONE;
      else if (do_pop && !do_push)
         count_next = fifo_count - CNT_ONE;
   end

   // Status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_hold_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         cpu_hold_q <= (count_next >= HOLD_LEVEL);
         overflow_q <= overflow_q | drop;
      end
   end

   assign bit_done = (baud_cnt == BAUD_LAST);

   // Transmitter state register
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Transmitter next-state logic; every non-idle transition happens at the
   // end of a full bit period
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!fifo_empty) state_next = START;
         START:   if (bit_done) state_next = DATA;
         DATA:    if (bit_done && (bit_idx == LAST_BIT)) state_next = STOP;
         STOP:    if (bit_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Transmitter output logic: line level implied by the current state
   always_comb begin
      txd_next = IDLE_LEVEL;
      case (state)
         IDLE:    txd_next = IDLE_LEVEL;
         START:   txd_next = START_BIT;
         DATA:    txd_next = data_reg[bit_idx];
         STOP:    txd_next = STOP_BIT;
         default: txd_next = IDLE_LEVEL;
      endcase
   end

   // Baud counter, bit index and data holding register. The counter restarts
   // at every bit boundary, which is also the only point a state can change.
   always_ff @(posedge clk) begin
      if (reset) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
         data_reg <= '0;
         txd_q    <= IDLE_LEVEL;
      end else begin
         txd_q <= txd_next;
         if ((state == IDLE) || bit_done)
            baud_cnt <= '0;
         else
            baud_cnt <= baud_cnt + 1'b1;
         if (state == START)
            bit_idx <= '0;
         else if ((state == DATA) && bit_done)
            bit_idx <= bit_idx + 1'b1;
         if (do_pop)
            data_reg <= fifo_head;
      end
   end

   assign txd      = txd_q;
   assign cpu_hold = cpu_hold_q;
   assign overflow = overflow_q;
   assign busy     = (fifo_count != '0) || (state != IDLE);

endmodule

// File: tb/tb_stdout_uart.sv
// ---------------------------------------------------------------------------
// tb_stdout_uart
// Directed bench for stdout_uart with CLKS_PER_BIT=4, FIFO_DEPTH=4. A
// background receiver decodes frames off txd so byte order and inter-frame
// spacing can be checked for multi-byte sequences.
// ---------------------------------------------------------------------------
module tb_stdout_uart;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = CPB * 10;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] stdout;
   logic       stdout_en;
   logic       txd;
   logic       cpu_hold;
   logic       busy;
   logic       overflow;
   logic [2:0] fifo_count;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   logic       rx_enable = 1'b0;
   logic [7:0] rx_q[$];
   int         rx_cyc[$];
   logic       rx_stop[$];

   stdout_uart #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .stdout     (stdout),
      .stdout_en  (stdout_en),
      .txd        (txd),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Advance one clock and settle just past the edge
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One-cycle stdout_en strobe carrying byte b
   task automatic applyStimulus(input logic [7:0] b);
      stdout    = b;
      stdout_en = 1'b1;
      tick();
      stdout_en = 1'b0;
   endtask

   task automatic doReset;
      reset     = 1'b1;
      stdout_en = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Called when txd is in its first start-bit cycle; checks every cycle
   task automatic checkFrame(input logic [7:0] b, input string tag);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < FRAME; i++) begin
         checkOutput(tag, txd, f[i / CPB]);
         tick();
      end
   endtask

   task automatic waitIdle(input int max_cycles);
      for (int i = 0; i < max_cycles && busy !== 1'b0; i++)
         tick();
      tick();
      tick();
   endtask

   // Background receiver: samples mid-bit, records byte, start cycle, stop bit
   initial begin
      logic [7:0] d;
      logic       sb;
      int         t0;
      forever begin
         @(posedge clk);
         #2;
         if (rx_enable && txd === 1'b0) begin
            t0 = cyc;
            repeat (CPB / 2) @(posedge clk);
            for (int b = 0; b < 8; b++) begin
               repeat (CPB) @(posedge clk);
               #2;
               d[b] = txd;
            end
            repeat (CPB) @(posedge clk);
            #2;
            sb = txd;
            rx_q.push_back(d);
            rx_cyc.push_back(t0);
            rx_stop.push_back(sb);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int bad;
      reset     = 1'b1;
      stdout    = 8'h00;
      stdout_en = 1'b0;
      tick();
      tick();

      // Reset state
      checkOutput("rst_txd", txd, 1);
      checkOutput("rst_count", fifo_count, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_overflow", overflow, 0);
      checkOutput("rst_cpu_hold", cpu_hold, 0);
      reset = 1'b0;
      tick();

      // Single byte 0x41: txd low two edges after the accepting edge
      applyStimulus(8'h41);
      checkOutput("s1_count_push", fifo_count, 1);
      checkOutput("s1_txd_e0", txd, 1);
      tick();
      checkOutput("s1_txd_e1", txd, 1);
      checkOutput("s1_count_pop", fifo_count, 0);
      checkOutput("s1_busy", busy, 1);
      tick();
      checkFrame(8'h41, "s1_frame");
      checkOutput("s1_busy_end", busy, 0);
      checkOutput("s1_txd_end", txd, 1);

      // Level held high: exactly one frame
      stdout    = 8'h55;
      stdout_en = 1'b1;
      tick();
      checkOutput("lvl_count_push", fifo_count, 1);
      tick();
      checkOutput("lvl_count_pop", fifo_count, 0);
      checkOutput("lvl_txd_e1", txd, 1);
      tick();
      checkFrame(8'h55, "lvl_frame");
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (txd !== 1'b1 || fifo_count !== 3'd0) bad++;
         tick();
      end
      checkOutput("lvl_no_second", bad, 0);
      checkOutput("lvl_busy", busy, 0);
      stdout_en = 1'b0;
      tick();

      // Six strobes two cycles apart: hold, overflow, ordered frames
      doReset();
      rx_q.delete();
      rx_cyc.delete();
      rx_stop.delete();
      rx_enable = 1'b1;
      applyStimulus(8'h01);
      tick();
      applyStimulus(8'h02);
      checkOutput("ovf_count1", fifo_count, 1);
      checkOutput("ovf_hold0", cpu_hold, 0);
      tick();
      applyStimulus(8'h03);
      checkOutput("ovf_count2", fifo_count, 2);
      checkOutput("ovf_hold1", cpu_hold, 1);
      tick();
      applyStimulus(8'h04);
      checkOutput("ovf_count3", fifo_count, 3);
      tick();
      applyStimulus(8'h05);
      checkOutput("ovf_count4", fifo_count, 4);
      checkOutput("ovf_flag0", overflow, 0);
      tick();
      applyStimulus(8'h06);
      checkOutput("ovf_count_full", fifo_count, 4);
      checkOutput("ovf_flag1", overflow, 1);
      waitIdle(8 * FRAME);
      checkOutput("ovf_busy_drain", busy, 0);
      checkOutput("ovf_frames", rx_q.size(), 5);
      for (int i = 0; i < rx_q.size(); i++) begin
         checkOutput("ovf_byte", rx_q[i], i + 1);
         checkOutput("ovf_stop", rx_stop[i], 1);
         if (i > 0) checkOutput("ovf_gap", rx_cyc[i] - rx_cyc[i-1], FRAME + 1);
      end
      checkOutput("ovf_sticky", overflow, 1);
      checkOutput("ovf_hold_drop", cpu_hold, 0);

      // Push coinciding with pop while full
      doReset();
      rx_q.delete();
      rx_cyc.delete();
      rx_stop.delete();
      applyStimulus(8'hA0);
      tick();
      applyStimulus(8'hA1);
      tick();
      applyStimulus(8'hA2);
      tick();
      applyStimulus(8'hA3);
      tick();
      applyStimulus(8'hA4);
      checkOutput("pp_count_full", fifo_count, 4);
      repeat (33) tick();
      checkOutput("pp_count_before", fifo_count, 4);
      applyStimulus(8'hA5);
      checkOutput("pp_count_after", fifo_count, 4);
      checkOutput("pp_overflow", overflow, 0);
      checkOutput("pp_hold", cpu_hold, 1);
      waitIdle(10 * FRAME);
      checkOutput("pp_frames", rx_q.size(), 6);
      for (int i = 0; i < rx_q.size(); i++) begin
         checkOutput("pp_byte", rx_q[i], 8'hA0 + i);
         if (i > 0) checkOutput("pp_gap", rx_cyc[i] - rx_cyc[i-1], FRAME + 1);
      end
      checkOutput("pp_overflow_end", overflow, 0);
      rx_enable = 1'b0;

      // Reset during data bit 3 of 0x3C with two bytes queued
      doReset();
      applyStimulus(8'h3C);
      tick();
      applyStimulus(8'h11);
      tick();
      applyStimulus(8'h22);
      repeat (14) tick();
      checkOutput("mr_txd_bit3", txd, 1);
      checkOutput("mr_count_pre", fifo_count, 2);
      checkOutput("mr_hold_pre", cpu_hold, 1);
      reset = 1'b1;
      tick();
      checkOutput("mr_txd", txd, 1);
      checkOutput("mr_count", fifo_count, 0);
      checkOutput("mr_busy", busy, 0);
      checkOutput("mr_overflow", overflow, 0);
      checkOutput("mr_hold", cpu_hold, 0);
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (txd !== 1'b1 || busy !== 1'b0) bad++;
      end
      checkOutput("mr_no_frames", bad, 0);

      // stdout_en high across reset release
      reset     = 1'b1;
      stdout    = 8'h77;
      stdout_en = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (fifo_count !== 3'd0 || busy !== 1'b0 || txd !== 1'b1) bad++;
      end
      checkOutput("rel_no_accept", bad, 0);
      stdout_en = 1'b0;
      tick();
      checkOutput("rel_count_low", fifo_count, 0);
      stdout_en = 1'b1;
      tick();
      checkOutput("rel_count_rise", fifo_count, 1);
      stdout_en = 1'b0;
      waitIdle(3 * FRAME);
      checkOutput("rel_busy_end", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stdout_uart.md
STDOUT_UART -- requirements
Module: stdout_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, clock cycles per UART bit (minimum 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, byte FIFO entries (power of two, minimum 4).
REQ-003 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port stdout, input, 8, output byte from the processor.
REQ-006 SHALL have port stdout_en, input, 1, byte-valid strobe from the processor (level may persist while the processor is halted).
REQ-007 SHALL have port txd, output, 1, UART 8N1 serial line, idle high.
REQ-008 SHALL have port cpu_hold, output, 1, high requests that the processor enable be deasserted (FIFO nearly full).
REQ-009 SHALL have port busy, output, 1, high while the FIFO is non-empty or a frame is in flight.
REQ-010 SHALL have port overflow, output, 1, sticky flag: a byte was dropped because the FIFO was full.
REQ-011 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-012 SHALL register stdout_en each cycle and accept a byte only on its rising edge (stdout_en=1, previous=0), so one processor output yields exactly one FIFO write.
REQ-013 SHALL write the accepted byte into the FIFO on the same clock edge the rising edge is sampled.
REQ-014 SHALL drop an accepted byte when the FIFO is full (fifo_count==FIFO_DEPTH), leave FIFO contents unchanged, and set overflow to 1 until reset.
REQ-015 SHALL perform push and pop on the same edge when both occur, leaving fifo_count unchanged, including when full (pop frees the slot; byte is accepted, no overflow).
REQ-016 SHALL drive cpu_hold as a registered output, 1 when fifo_count >= FIFO_DEPTH-2, else 0.
REQ-017 SHALL implement transmitter states IDLE, START, DATA, STOP.
REQ-018 IDLE: txd=1; when FIFO non-empty, pop the head byte into the shift register and go to START on the same edge.
REQ-019 START: txd=0 for CLKS_PER_BIT cycles, then DATA.
REQ-020 DATA: transmit 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit bit index; after bit 7, go to STOP.
REQ-021 STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE; consequently consecutive frames are separated by exactly one idle clock.
REQ-022 txd SHALL be a registered output; its first low cycle is the second clock edge after the edge that sampled the stdout_en rising edge (FIFO empty, IDLE).
REQ-023 Baud counter SHALL count 0..CLKS_PER_BIT-1, reset to 0 on every state or bit change, and never wrap mid-bit.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the byte order out SHALL equal the byte order in.
REQ-025 busy SHALL equal (fifo_count!=0) OR (state!=IDLE).

Reset
REQ-026 On reset (including mid-frame): state=IDLE, txd=1, FIFO emptied (fifo_count=0), cpu_hold=0, busy=0, overflow=0, edge register=0, baud counter and bit index=0.
REQ-027 A stdout_en already high when reset deasserts SHALL NOT be accepted until it falls and rises again.

Structure
REQ-028 Shared package stdout_uart_pkg SHALL hold the transmitter state enum and the 8N1 frame constants (start bit value, data bits=8, stop bit value).
REQ-029 The FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, count).

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Single byte 0x41, one-cycle stdout_en -> txd low 2 edges later, then bits 1,0,0,0,0,0,1,0 at 4 clocks each, stop high 4 clocks; total frame 40 clocks; busy falls after stop.
REQ-031 stdout_en held high 20 cycles with stdout=0x55 -> exactly one frame transmitted, fifo_count peaks at 1.
REQ-032 Six bytes 0x01..0x06 on strobes 2 cycles apart -> cpu_hold rises when fifo_count reaches 2; bytes beyond capacity dropped, overflow=1; frames carry bytes in order without gaps other than the one idle clock.
REQ-033 Push coinciding with pop while fifo_count=4 -> count stays 4, overflow stays 0, new byte sent last.
REQ-034 Reset asserted during DATA bit 3 of frame 0x3C with 2 bytes queued -> next cycle txd=1, fifo_count=0, busy=0, overflow=0; no further frames.
REQ-035 stdout_en high across reset release -> no byte accepted until stdout_en toggles low then high.
